stb_coalesce_buffer: RTL and testbench

STB_COALESCE_BUFFER -- requirements
Module: stb_coalesce_buffer

---
 rtl/stb_pkg.sv | 21 ++
 rtl/stb_fwd_merge.sv | 47 ++++
 rtl/stb_coalesce_buffer.sv | 179 +++++++++++++++++
 tb/tb_stb_coalesce_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// Shared types and default sizing for the store buffer slice.
// Optional store coalescing is enabled by defining STB_COALESCE_EN.
package stb_pkg;

  localparam int unsigned STB_ADDR_WIDTH = 32;
  localparam int unsigned STB_DATA_WIDTH = 32;
  localparam int unsigned STB_SEL_WIDTH  = STB_DATA_WIDTH / 8;
  localparam int unsigned STB_FIFO_DEPTH = 8;

  typedef enum logic {
    IDLE,
    DRAIN
  } stb_state_e;

  typedef struct packed {
    logic [STB_ADDR_WIDTH-1:0] addr;
    logic [STB_DATA_WIDTH-1:0] data;
    logic [STB_SEL_WIDTH-1:0]  sel;
  } stb_entry_t;

endpackage

// File: rtl/stb_fwd_merge.sv
// Per-byte-lane store-to-load forwarding: the youngest valid entry matching
// the load word address and owning the lane supplies that byte.
module stb_fwd_merge
  import stb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = STB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = STB_DATA_WIDTH,
  parameter int unsigned BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH     = STB_FIFO_DEPTH
) (
  input  logic [FIFO_DEPTH-1:0]         ent_valid,
  input  logic [ADDR_WIDTH-1:0]         ent_addr [FIFO_DEPTH],
  input  logic [DATA_WIDTH-1:0]         ent_data [FIFO_DEPTH],
  input  logic [BYTE_SEL_WIDTH-1:0]     ent_sel  [FIFO_DEPTH],
  input  logic [$clog2(FIFO_DEPTH)-1:0] head,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  output logic [BYTE_SEL_WIDTH-1:0]     fwd_mask,
  output logic [DATA_WIDTH-1:0]         fwd_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTE_SEL_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] ld_word;
  logic [PTR_W-1:0]      idx;

  assign ld_word = ld_addr & ALIGN_MASK;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_word)) begin
        for (int unsigned b = 0; b < BYTE_SEL_WIDTH; b++) begin
          if (ent_sel[idx][b]) begin
            fwd_mask[b]         = 1'b1;
            fwd_data[b*8 +: 8]  = ent_data[idx][b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/stb_coalesce_buffer.sv
// Store buffer: circular FIFO of word-aligned stores drained to the dcache,
// with load forwarding and flush. STB_COALESCE_EN enables same-word merging.
module stb_coalesce_buffer
  import stb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = STB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = STB_DATA_WIDTH,
  parameter int unsigned BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH     = STB_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lsudbus2stb_req,
  input  logic [ADDR_WIDTH-1:0]         lsudbus2stb_addr,
  input  logic [DATA_WIDTH-1:0]         lsudbus2stb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0]     lsudbus2stb_sel_byte,
  output logic                          stb2dbuslsu_ack,
  output logic                          stb2dbuslsu_stall,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  output logic [BYTE_SEL_WIDTH-1:0]     ld_fwd_mask,
  output logic [DATA_WIDTH-1:0]         ld_fwd_data,
  output logic                          stb2dcache_req,
  output logic [ADDR_WIDTH-1:0]         stb2dcache_addr,
  output logic [DATA_WIDTH-1:0]         stb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0]     stb2dcache_sel_byte,
  output logic                          stb2dcache_w_en,
  input  logic                          dcache2stb_ack,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          stb2dcache_empty,
  output logic [$clog2(FIFO_DEPTH):0]   stb_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTE_SEL_WIDTH - 1);

  logic [FIFO_DEPTH-1:0]     ent_valid;
  logic [ADDR_WIDTH-1:0]     ent_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     ent_data [FIFO_DEPTH];
  logic [BYTE_SEL_WIDTH-1:0] ent_sel  [FIFO_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] youngest;
  logic [CNT_W-1:0] count;

  stb_state_e state;
  stb_state_e state_n;

  logic                  flush_pending;
  logic                  full;
  logic                  empty;
  logic                  coal_hit;
  logic                  acc;
  logic                  push;
  logic                  merge;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] st_word;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign youngest = tail - PTR_W'(1);
  assign st_word  = lsudbus2stb_addr & ALIGN_MASK;

`ifdef STB_COALESCE_EN
  // The head being written to the dcache must not change under the handshake.
  assign coal_hit = ent_valid[youngest] && (ent_addr[youngest] == st_word) &&
                    !((state == DRAIN) && (youngest == head));
`else
  assign coal_hit = 1'b0;
`endif

  assign acc   = lsudbus2stb_req & ~flush_pending & (~full | coal_hit);
  assign push  = acc & ~coal_hit;
  assign merge = acc & coal_hit;
  assign pop   = (state == DRAIN) & dcache2stb_ack;

  assign stb2dbuslsu_ack   = acc;
  assign stb2dbuslsu_stall = lsudbus2stb_req & ~acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid     <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
      if (flush_done) begin
        flush_pending <= 1'b0;
      end else if (flush_req) begin
        flush_pending <= 1'b1;
      end
    end
  end

  // Payload needs no reset: ent_valid qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_word;
      ent_data[tail] <= lsudbus2stb_wdata;
      ent_sel[tail]  <= lsudbus2stb_sel_byte;
    end else if (merge) begin
      for (int unsigned b = 0; b < BYTE_SEL_WIDTH; b++) begin
        if (lsudbus2stb_sel_byte[b]) begin
          ent_data[youngest][b*8 +: 8] <= lsudbus2stb_wdata[b*8 +: 8];
        end
      end
      ent_sel[youngest] <= ent_sel[youngest] | lsudbus2stb_sel_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    stb2dcache_req = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        stb2dcache_req = 1'b1;
        if (dcache2stb_ack && (count <= CNT_W'(1))) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stb2dcache_w_en     = stb2dcache_req;
  assign stb2dcache_addr     = ent_addr[head];
  assign stb2dcache_wdata    = ent_data[head];
  assign stb2dcache_sel_byte = ent_sel[head];
  assign stb2dcache_empty    = empty;
  assign stb_count           = count;
  assign flush_done          = flush_pending & empty & (state == IDLE);

  stb_fwd_merge #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTE_SEL_WIDTH(BYTE_SEL_WIDTH),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_fwd_merge (
    .ent_valid(ent_valid),
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_sel  (ent_sel),
    .head     (head),
    .ld_addr  (ld_addr),
    .fwd_mask (ld_fwd_mask),
    .fwd_data (ld_fwd_data)
  );

endmodule

// File: tb/tb_stb_coalesce_buffer.sv
// Scoreboard bench for stb_coalesce_buffer: accepted stores queue their
// expected dcache write; a monitor checks each drain handshake against it.
module tb_stb_coalesce_buffer;
  import stb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsudbus2stb_req;
  logic [AW-1:0] lsudbus2stb_addr;
  logic [DW-1:0] lsudbus2stb_wdata;
  logic [SW-1:0] lsudbus2stb_sel_byte;
  logic          stb2dbuslsu_ack;
  logic          stb2dbuslsu_stall;
  logic [AW-1:0] ld_addr;
  logic [SW-1:0] ld_fwd_mask;
  logic [DW-1:0] ld_fwd_data;
  logic          stb2dcache_req;
  logic [AW-1:0] stb2dcache_addr;
  logic [DW-1:0] stb2dcache_wdata;
  logic [SW-1:0] stb2dcache_sel_byte;
  logic          stb2dcache_w_en;
  logic          dcache2stb_ack;
  logic          flush_req;
  logic          flush_done;
  logic          stb2dcache_empty;
  logic [3:0]    stb_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  stb_entry_t  exp_q[$];

  always #5 clk = ~clk;

  stb_coalesce_buffer #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BYTE_SEL_WIDTH(SW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsudbus2stb_req     (lsudbus2stb_req),
    .lsudbus2stb_addr    (lsudbus2stb_addr),
    .lsudbus2stb_wdata   (lsudbus2stb_wdata),
    .lsudbus2stb_sel_byte(lsudbus2stb_sel_byte),
    .stb2dbuslsu_ack     (stb2dbuslsu_ack),
    .stb2dbuslsu_stall   (stb2dbuslsu_stall),
    .ld_addr             (ld_addr),
    .ld_fwd_mask         (ld_fwd_mask),
    .ld_fwd_data         (ld_fwd_data),
    .stb2dcache_req      (stb2dcache_req),
    .stb2dcache_addr     (stb2dcache_addr),
    .stb2dcache_wdata    (stb2dcache_wdata),
    .stb2dcache_sel_byte (stb2dcache_sel_byte),
    .stb2dcache_w_en     (stb2dcache_w_en),
    .dcache2stb_ack      (dcache2stb_ack),
    .flush_req           (flush_req),
    .flush_done          (flush_done),
    .stb2dcache_empty    (stb2dcache_empty),
    .stb_count           (stb_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < SW; b++) begin
      if (s[b]) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Drain monitor: a handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    stb_entry_t e;
    if (!rst && stb2dcache_req && dcache2stb_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got addr 0x%0h expected no write", stb2dcache_addr);
      end else begin
        e = exp_q.pop_front();
        chk("drain_addr", stb2dcache_addr, e.addr);
        chk("drain_sel", stb2dcache_sel_byte, e.sel);
        chk("drain_data", stb2dcache_wdata & lane_mask(e.sel), e.data & lane_mask(e.sel));
        chk("drain_w_en", stb2dcache_w_en, 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input bit exp_acc, input string name);
    stb_entry_t e;
    lsudbus2stb_req      = 1'b1;
    lsudbus2stb_addr     = a;
    lsudbus2stb_wdata    = d;
    lsudbus2stb_sel_byte = s;
    #1;
    chk({name, "_ack"}, stb2dbuslsu_ack, exp_acc);
    chk({name, "_stall"}, stb2dbuslsu_stall, !exp_acc);
    if (exp_acc) begin
      e.addr = a & ~32'h3;
      e.data = d;
      e.sel  = s;
      exp_q.push_back(e);
    end
    tick();
    lsudbus2stb_req = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int unsigned n;
    n = 0;
    dcache2stb_ack = 1'b1;
    while (!(stb2dcache_empty && !stb2dcache_req) && n < 40) begin
      tick();
      n++;
    end
    dcache2stb_ack = 1'b0;
    chk({name, "_drain_bound"}, n < 40, 1'b1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned pulses, hs_n, done_k, second_hs, acc_k;
    bit          accepted;
    stb_entry_t  e;

    rst                  = 1'b1;
    lsudbus2stb_req      = 1'b0;
    lsudbus2stb_addr     = '0;
    lsudbus2stb_wdata    = '0;
    lsudbus2stb_sel_byte = '0;
    ld_addr              = '0;
    dcache2stb_ack       = 1'b0;
    flush_req            = 1'b0;
    tick();
    tick();
    chk("rst_req", stb2dcache_req, 1'b0);
    chk("rst_w_en", stb2dcache_w_en, 1'b0);
    chk("rst_empty", stb2dcache_empty, 1'b1);
    chk("rst_count", stb_count, 4'd0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_lsu_ack", stb2dbuslsu_ack, 1'b0);
    rst = 1'b0;

    // Ack while idle must not disturb anything
    dcache2stb_ack = 1'b1;
    tick();
    tick();
    dcache2stb_ack = 1'b0;
    chk("idle_ack_count", stb_count, 4'd0);
    chk("idle_ack_req", stb2dcache_req, 1'b0);

    // Fill to full with the dcache stalled
    for (int i = 0; i < 8; i++) begin
      store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1, "fill");
    end
    chk("fill_count", stb_count, 4'd8);
    store(32'h120, 32'hDEAD_BEEF, 4'hF, 1'b0, "fill_9th");
    for (int k = 0; k < 3; k++) begin
      chk("fill_head_req", stb2dcache_req, 1'b1);
      chk("fill_head_addr", stb2dcache_addr, 32'h100);
      tick();
    end
    // Full is judged before the same-cycle pop
    lsudbus2stb_req      = 1'b1;
    lsudbus2stb_addr     = 32'h124;
    lsudbus2stb_wdata    = 32'h1234_5678;
    lsudbus2stb_sel_byte = 4'hF;
    dcache2stb_ack       = 1'b1;
    #1;
    chk("full_pop_stall", stb2dbuslsu_stall, 1'b1);
    chk("full_pop_ack", stb2dbuslsu_ack, 1'b0);
    tick();
    lsudbus2stb_req = 1'b0;
    dcache2stb_ack  = 1'b0;
    chk("full_pop_count", stb_count, 4'd7);
    drain_all("fill");

    // Back-to-back drain
    store(32'h100, 32'hB000_0000, 4'hF, 1'b1, "drain");
    store(32'h104, 32'hB000_0001, 4'hF, 1'b1, "drain");
    store(32'h108, 32'hB000_0002, 4'hF, 1'b1, "drain");
    dcache2stb_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b2b_req", stb2dcache_req, 1'b1);
      chk("b2b_addr", stb2dcache_addr, 32'h100 + 32'(4 * k));
      tick();
    end
    dcache2stb_ack = 1'b0;
    chk("b2b_end_req", stb2dcache_req, 1'b0);
    chk("b2b_end_empty", stb2dcache_empty, 1'b1);

    // Forwarding across two entries to the same word (head in flight)
    store(32'h200, 32'h1122_3344, 4'b0011, 1'b1, "fwd");
    tick();
    tick();
    store(32'h200, 32'hAABB_CCDD, 4'b0110, 1'b1, "fwd");
    ld_addr = 32'h202;
    #1;
    chk("fwd_mask", ld_fwd_mask, 4'b0111);
    chk("fwd_data", ld_fwd_data, 32'h00BB_CC44);
    chk("fwd_count", stb_count, 4'd2);
    ld_addr = 32'h204;
    #1;
    chk("fwd_miss_mask", ld_fwd_mask, 4'b0000);
    chk("fwd_miss_data", ld_fwd_data, 32'h0);
    drain_all("fwd");

    // Flush with a store waiting behind it
    store(32'h500, 32'hC000_0000, 4'hF, 1'b1, "flush");
    store(32'h504, 32'hC000_0001, 4'hF, 1'b1, "flush");
    flush_req = 1'b1;
    tick();
    flush_req            = 1'b0;
    lsudbus2stb_req      = 1'b1;
    lsudbus2stb_addr     = 32'h508;
    lsudbus2stb_wdata    = 32'hC000_0002;
    lsudbus2stb_sel_byte = 4'hF;
    dcache2stb_ack       = 1'b1;
    pulses    = 0;
    hs_n      = 0;
    done_k    = 0;
    second_hs = 0;
    acc_k     = 0;
    accepted  = 1'b0;
    #1;
    chk("flush_stall", stb2dbuslsu_stall, 1'b1);
    for (int unsigned k = 0; k < 12; k++) begin
      if (!accepted && stb2dbuslsu_ack) begin
        accepted = 1'b1;
        acc_k    = k;
        e.addr   = 32'h508;
        e.data   = 32'hC000_0002;
        e.sel    = 4'hF;
        exp_q.push_back(e);
      end
      if (flush_done) begin
        pulses++;
        done_k = k;
      end
      if (stb2dcache_req && dcache2stb_ack) begin
        hs_n++;
        if (hs_n == 2) second_hs = k;
      end
      tick();
      if (accepted) lsudbus2stb_req = 1'b0;
    end
    lsudbus2stb_req = 1'b0;
    dcache2stb_ack  = 1'b0;
    chk("flush_pulses", pulses, 1);
    chk("flush_done_cycle", done_k, second_hs + 1);
    chk("flush_accept_cycle", acc_k, done_k + 1);
    drain_all("flush");

    // Reset with an unacked head in flight
    store(32'h600, 32'hD000_0000, 4'hF, 1'b1, "rstmid");
    store(32'h604, 32'hD000_0001, 4'hF, 1'b1, "rstmid");
    chk("rstmid_req_before", stb2dcache_req, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("rstmid_req", stb2dcache_req, 1'b0);
    chk("rstmid_count", stb_count, 4'd0);
    chk("rstmid_empty", stb2dcache_empty, 1'b1);
    tick();
    chk("rstmid_stays_empty", stb2dcache_empty, 1'b1);

`ifdef STB_COALESCE_EN
    // Two partial stores to one word merge behind a different in-flight head
    store(32'h400, 32'hE000_0000, 4'hF, 1'b1, "coal_head");
    tick();
    tick();
    store(32'h300, 32'h0000_00AA, 4'b0001, 1'b1, "coal1");
    store(32'h300, 32'h00BB_0000, 4'b0100, 1'b1, "coal2");
    chk("coal_count", stb_count, 4'd2);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    e.addr = 32'h300;
    e.data = 32'h00BB_00AA;
    e.sel  = 4'b0101;
    exp_q.push_back(e);
    drain_all("coal");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
